sdram_block_master: RTL and testbench

//   Parametrised Avalon-MM master that runs one block operation on SDRAM per

---
 rtl/sdram_block_master_if.sv | 24 ++
 rtl/sdram_block_master.sv | 140 ++++++++++++++
 tb/tb_sdram_block_master.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_block_master_if.sv
// Avalon-MM bus between the block master and the SDRAM controller slave port.
interface sdram_block_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;
  logic                avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/sdram_block_master.sv
// Block-operation Avalon-MM master: FILL, VERIFY or CHECKSUM over a run of SDRAM
// words, started by a rising edge on ready and acknowledged with done.
module sdram_block_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 24,
  parameter int MAX_PENDING = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ready,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  input  logic [DATA_W-1:0] seed,
  output logic              done,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [31:0]       result,
  sdram_block_master_if.master avm
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
  localparam logic [7:0]        MAXP = 8'(MAX_PENDING);

  state_t            state, state_nxt;
  logic              ready_q;
  logic [1:0]        mode_r;
  logic [LEN_W-1:0]  len_r, issued, issued_inc;
  logic [ADDR_W-1:0] addr_r, rcv_addr;
  logic [DATA_W-1:0] data_r, exp_data;
  logic [7:0]        pending, pending_nxt;
  logic              start, req_read, req_write, rd_accept, wr_accept, rd_ok, last_issue;

  assign start      = (state == S_IDLE) && ready && !ready_q;
  assign req_write  = (state == S_WRITE);
  assign req_read   = (state == S_READ) && (issued < len_r) && (pending < MAXP);
  assign rd_accept  = req_read && !avm.avm_waitrequest;
  assign wr_accept  = req_write && !avm.avm_waitrequest;
  assign issued_inc = issued + 1'b1;
  assign last_issue = (issued_inc == len_r);
  // Returns that arrive with nothing outstanding (e.g. after a reset) are stale.
  assign rd_ok      = avm.avm_readdatavalid && (pending != 8'd0);

  assign avm.avm_address    = addr_r;
  assign avm.avm_read       = req_read;
  assign avm.avm_write      = req_write;
  assign avm.avm_writedata  = data_r;
  assign avm.avm_byteenable = '1;

  assign done = (state == S_DONE);
  assign busy = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);

  always_comb begin
    pending_nxt = pending;
    if (rd_accept && !rd_ok)      pending_nxt = pending + 8'd1;
    else if (!rd_accept && rd_ok) pending_nxt = pending - 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_words == '0)   state_nxt = S_DONE;
          else if (mode == 2'd0) state_nxt = S_WRITE;
          else                   state_nxt = S_READ;
        end
      end
      S_WRITE: if (wr_accept && last_issue) state_nxt = S_DONE;
      S_READ:  if (rd_accept && last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if (pending_nxt == 8'd0)     state_nxt = S_DONE;
      S_DONE:  if (!ready)                  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q  <= 1'b0;
      mode_r   <= 2'd0;
      len_r    <= '0;
      issued   <= '0;
      addr_r   <= '0;
      rcv_addr <= '0;
      data_r   <= '0;
      exp_data <= '0;
      pending  <= 8'd0;
      result   <= 32'd0;
      error    <= 1'b0;
      err_addr <= '0;
    end else begin
      ready_q <= ready;
      pending <= pending_nxt;
      if (start) begin
        mode_r   <= mode;
        len_r    <= num_words;
        issued   <= '0;
        addr_r   <= base_addr;
        rcv_addr <= base_addr;
        data_r   <= seed;
        exp_data <= seed;
        result   <= 32'd0;
        error    <= 1'b0;
        err_addr <= '0;
      end
      if (wr_accept || rd_accept) begin
        issued <= issued_inc;
        addr_r <= addr_r + STEP;
        data_r <= data_r + 1'b1;
      end
      if (wr_accept) result <= result + 32'd1;
      // Reads come back in order, so the j-th return is checked against word j.
      if (rd_ok) begin
        exp_data <= exp_data + 1'b1;
        rcv_addr <= rcv_addr + STEP;
        if (mode_r == 2'd1) begin
          if (avm.avm_readdata != exp_data) begin
            result <= result + 32'd1;
            if (!error) begin
              error    <= 1'b1;
              err_addr <= rcv_addr;
            end
          end
        end else begin
          result <= result + 32'(avm.avm_readdata);
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_block_master.sv
// Scoreboard bench for sdram_block_master: a slave memory model serves the bus,
// monitors pop expected writes and completion results as the DUT presents them.
module tb_sdram_block_master;
  localparam int ADDR_W = 32, DATA_W = 32, LEN_W = 24, MAX_PENDING = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              ready;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_words;
  logic [DATA_W-1:0] seed;
  logic              done, busy, error;
  logic [ADDR_W-1:0] err_addr;
  logic [31:0]       result;

  sdram_block_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm_bus ();

  sdram_block_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ready(ready), .mode(mode),
    .base_addr(base_addr), .num_words(num_words), .seed(seed),
    .done(done), .busy(busy), .error(error), .err_addr(err_addr),
    .result(result), .avm(avm_bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] result; logic error; logic [31:0] err_addr; } done_t;
  typedef struct { logic [31:0] addr; int due; } rd_t;

  wr_t   exp_wr_q[$];
  done_t exp_done_q[$];
  rd_t   rd_q[$];
  logic [31:0] mem [logic [31:0]];

  int tests = 0, fails = 0, cyc = 0;
  bit rand_wait = 1'b0;
  int lat_min = 3, lat_max = 3;
  int tb_pending = 0, max_pending = 0, req_cycles = 0;
  int first_req_cyc = -1, last_wr_acc = -1, last_rdv = -1, done_cyc = -1, start_cyc = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave memory: decides waitrequest and read returns for the coming edge.
  initial begin
    logic prev_stall, prev_rd, prev_wr;
    logic [31:0] prev_addr, prev_data;
    prev_stall = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_data = '0;
    avm_bus.avm_waitrequest   = 1'b0;
    avm_bus.avm_readdatavalid = 1'b0;
    avm_bus.avm_readdata      = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && reset_n) begin
        check_output("hold_read",  avm_bus.avm_read,      prev_rd);
        check_output("hold_write", avm_bus.avm_write,     prev_wr);
        check_output("hold_addr",  avm_bus.avm_address,   prev_addr);
        check_output("hold_data",  avm_bus.avm_writedata, prev_data);
      end
      avm_bus.avm_waitrequest = rand_wait ? 1'($urandom_range(1, 0)) : 1'b0;
      if (rd_q.size() > 0 && rd_q[0].due <= cyc + 1) begin
        rd_t r;
        r = rd_q.pop_front();
        avm_bus.avm_readdatavalid = 1'b1;
        avm_bus.avm_readdata = mem.exists(r.addr) ? mem[r.addr] : 32'h0;
        last_rdv = cyc + 1;
        if (tb_pending > 0) tb_pending--;
      end else begin
        avm_bus.avm_readdatavalid = 1'b0;
      end
      if (avm_bus.avm_read || avm_bus.avm_write) begin
        req_cycles++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (avm_bus.avm_write && !avm_bus.avm_waitrequest) begin
        if (exp_wr_q.size() == 0) check_output("unexpected_write", 1, 0);
        else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check_output("wr_addr", avm_bus.avm_address, e.addr);
          check_output("wr_data", avm_bus.avm_writedata, e.data);
        end
        mem[avm_bus.avm_address] = avm_bus.avm_writedata;
        last_wr_acc = cyc + 1;
      end
      if (avm_bus.avm_read && !avm_bus.avm_waitrequest) begin
        rd_t r;
        r.addr = avm_bus.avm_address;
        r.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
        if (rd_q.size() > 0 && r.due < rd_q[$].due) r.due = rd_q[$].due;
        rd_q.push_back(r);
        tb_pending++;
        if (tb_pending > max_pending) max_pending = tb_pending;
      end
      prev_stall = (avm_bus.avm_read || avm_bus.avm_write) && avm_bus.avm_waitrequest;
      prev_rd = avm_bus.avm_read; prev_wr = avm_bus.avm_write;
      prev_addr = avm_bus.avm_address; prev_data = avm_bus.avm_writedata;
    end
  end

  // Completion monitor.
  initial begin
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        done_cyc = cyc;
        if (exp_done_q.size() == 0) check_output("unexpected_done", 1, 0);
        else begin
          done_t d;
          d = exp_done_q.pop_front();
          check_output("result",   result,   d.result);
          check_output("error",    error,    d.error);
          check_output("err_addr", err_addr, d.err_addr);
          check_output("busy_at_done", busy, 0);
        end
      end
      done_prev = done;
    end
  end

  task automatic apply_stimulus(input logic [1:0] m, input logic [31:0] base, input logic [23:0] n,
                                input logic [31:0] sd, input logic [31:0] exp_res,
                                input logic exp_err, input logic [31:0] exp_ea, input string tag);
    done_t d;
    int k;
    d.result = exp_res; d.error = exp_err; d.err_addr = exp_ea;
    exp_done_q.push_back(d);
    if (m == 2'd0)
      for (int i = 0; i < int'(n); i++) begin
        wr_t w;
        w.addr = base + 32'(i) * 32'd4;
        w.data = sd + 32'(i);
        exp_wr_q.push_back(w);
      end
    @(negedge clk);
    mode = m; base_addr = base; num_words = n; seed = sd;
    first_req_cyc = -1; req_cycles = 0; done_cyc = -1;
    ready = 1'b1;
    start_cyc = cyc;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!done) check_output($sformatf("%s_timeout", tag), 0, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output($sformatf("%s_done_hold", tag), done, 1);
    ready = 1'b0;
    @(negedge clk);
    check_output($sformatf("%s_done_release", tag), done, 0);
  endtask

  initial begin
    int k;
    ready = 1'b0; mode = 2'd0; base_addr = '0; num_words = '0; seed = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_done",    done, 0);
    check_output("rst_busy",    busy, 0);
    check_output("rst_error",   error, 0);
    check_output("rst_result",  result, 0);
    check_output("rst_read",    avm_bus.avm_read, 0);
    check_output("rst_write",   avm_bus.avm_write, 0);
    check_output("rst_address", avm_bus.avm_address, 0);
    check_output("rst_be",      avm_bus.avm_byteenable, 4'hF);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    apply_stimulus(2'd0, 32'h100, 24'd4, 32'hA5A50000, 32'd4, 1'b0, 32'h0, "fill4");
    check_output("fill_first_req_latency", 64'(first_req_cyc - start_cyc), 1);
    check_output("fill_done_latency", 64'(done_cyc - last_wr_acc), 0);
    check_output("fill_wr_q_empty", exp_wr_q.size(), 0);

    rand_wait = 1'b1; lat_min = 3; lat_max = 7;
    apply_stimulus(2'd0, 32'h2000, 24'd16, 32'h11110000, 32'd16, 1'b0, 32'h0, "fill16");
    max_pending = 0;
    apply_stimulus(2'd1, 32'h2000, 24'd16, 32'h11110000, 32'd0, 1'b0, 32'h0, "verify16");
    check_output("pending_bound", max_pending <= MAX_PENDING, 1);
    check_output("verify_done_latency", 64'(done_cyc - last_rdv), 0);

    for (int i = 0; i < 8; i++) mem[32'h3000 + 32'(i) * 4] = 32'h55550000 + 32'(i);
    mem[32'h3008] = 32'h0;
    apply_stimulus(2'd1, 32'h3000, 24'd8, 32'h55550000, 32'd1, 1'b1, 32'h3008, "verify_bad1");
    mem[32'h3014] = 32'h12345678;
    apply_stimulus(2'd1, 32'h3000, 24'd8, 32'h55550000, 32'd2, 1'b1, 32'h3008, "verify_bad2");

    mem[32'h4000] = 32'd1; mem[32'h4004] = 32'd2; mem[32'h4008] = 32'd3; mem[32'h400C] = 32'hFFFFFFFF;
    apply_stimulus(2'd2, 32'h4000, 24'd4, 32'h0, 32'd5, 1'b0, 32'h0, "csum");
    check_output("csum_done_latency", 64'(done_cyc - last_rdv), 0);
    apply_stimulus(2'd3, 32'h4000, 24'd4, 32'h0, 32'd5, 1'b0, 32'h0, "csum_mode3");

    for (int m = 0; m < 3; m++) begin
      apply_stimulus(2'(m), 32'h6000, 24'd0, 32'h1, 32'd0, 1'b0, 32'h0, $sformatf("zero_m%0d", m));
      check_output($sformatf("zero_m%0d_no_req", m), req_cycles, 0);
      check_output($sformatf("zero_m%0d_done_fast", m), 64'(done_cyc - start_cyc) <= 2, 1);
    end

    rand_wait = 1'b0; lat_min = 5; lat_max = 5;
    @(negedge clk);
    mode = 2'd2; base_addr = 32'h5000; num_words = 24'd16; seed = '0; ready = 1'b1;
    k = 0;
    while (tb_pending < 3 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_output("rst_mid_reached_pending", tb_pending >= 3, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    ready = 1'b0;
    #1;
    check_output("rst_mid_read",   avm_bus.avm_read, 0);
    check_output("rst_mid_write",  avm_bus.avm_write, 0);
    check_output("rst_mid_busy",   busy, 0);
    check_output("rst_mid_result", result, 0);
    check_output("rst_mid_addr",   avm_bus.avm_address, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check_output("late_rdv_result", result, 0);
    check_output("late_rdv_done",   done, 0);
    check_output("late_rdv_busy",   busy, 0);
    apply_stimulus(2'd2, 32'h4000, 24'd4, 32'h0, 32'd5, 1'b0, 32'h0, "csum_after_rst");

    check_output("done_q_empty", exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
